stack_mem_responder: RTL and testbench
======================================

Name: stack_mem_responder

Overview:
- Memory-side responder for the multicycle datapath controller's MemRead/MemWrite/IRWrite strobes.
- Serves instruction fetch, stack push/pop and MDR transfers against a single-port word array.
- Uses a 4-phase ready handshake with configurable wait states, out-of-range detection and a post-reset zero-fill sweep.
- Sits between the MAR/MDR/IR registers and the RAM macro.

Parameters:
- AW, 8, address width; the array index is Addr[AW-1:0].
- DEPTH, 256, number of implemented words; must satisfy DEPTH <= 2**AW.
- DW, 16, data word width.
- WAIT_CYCLES, 1, extra stall cycles between request capture and access (0..15).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  read request level, held until MemReady.
- MemWrite  in  1  write request level, held until MemReady.
- IRWrite  in  1  qualifies a read as an instruction fetch.
- Addr  in  16  word address from MAR.
- WrData  in  DW  write data from MDR.
- RdData  out  DW  read data to MDR; registered.
- IR  out  DW  instruction register; registered.
- MemReady  out  1  one-cycle completion pulse.
- Busy  out  1  high in INIT, CAPT, WAIT and DONE.
- Error  out  1  one-cycle pulse for an illegal or out-of-range request.

Behaviour:
- Reset low, asynchronous, any state:
  - state=INIT, sweep counter=0, wait counter=0.
  - RdData=0, IR=0, MemReady=0, Error=0, Busy=1.
  - Any access in progress is abandoned; no partial write occurs.
- INIT:
  - Each cycle writes 0 to array[cnt], then cnt++.
  - After DEPTH cycles (cnt==DEPTH-1 written), go to IDLE.
  - Strobes are ignored during INIT.
- IDLE (Busy=0), evaluated each rising edge:
  - MemRead && MemWrite both high: pulse Error for 1 cycle, no access, move to DONE.
  - Exactly one strobe high: latch Addr, WrData, op and IRWrite; wait counter=WAIT_CYCLES; go to CAPT.
- CAPT:
  - Range check on the latched Addr.
  - If Addr >= DEPTH: flag out-of-range and go to ACC with the access suppressed.
  - Otherwise go to WAIT, or straight to ACC when WAIT_CYCLES=0.
- WAIT:
  - Decrement the wait counter each cycle; go to ACC on the cycle it reaches 0.
- ACC, single cycle:
  - Write: array[addr] <= data.
  - Read: RdData <= array[addr]; if IRWrite was latched, IR <= same word.
  - Out-of-range: write discarded, RdData <= 0, IR unchanged, Error pulses together with MemReady.
  - MemReady=1 for exactly this cycle (registered output, visible in the cycle after the ACC edge). Go to DONE.
- DONE:
  - Hold until MemRead==0 and MemWrite==0 are sampled, then go to IDLE.
  - This prevents a held strobe from re-triggering.
- Latency from strobe sampled to MemReady high is WAIT_CYCLES+3 edges (IDLE->CAPT->[WAIT]->ACC->MemReady registered).
- Strobe changes outside IDLE/DONE are ignored; the latched request is authoritative.
- RdData and IR hold their values between accesses; the array is not cleared except by the INIT sweep.
- Width rules:
  - Addr bits above AW participate only in the range check.
  - The wait counter is 4 bits.
  - The sweep counter is AW+1 bits so that DEPTH=2**AW terminates.

Decomposition:
- Package stack_mem_pkg holds:
  - the state enum (INIT, IDLE, CAPT, WAIT, ACC, DONE), encoded in 3 bits;
  - DW default;
  - the op-code localparams OP_RD and OP_WR.
- Sub-module mem_array_sp: single-port synchronous RAM.
  - Ports: Clk, we, addr[AW-1:0], wdata, rdata.
  - Read data is valid in the cycle after the address is presented.
  - ACC issues the read one cycle early from CAPT/WAIT so that RdData captures it at ACC.
- The FSM, counters and output registers stay in stack_mem_responder.

Test Plan:
- Reset then idle: release Reset, wait DEPTH+2 cycles.
  - Busy drops after exactly DEPTH INIT cycles.
  - A read of any address returns 16'h0000.
- Write/read, WAIT_CYCLES=1: MemWrite Addr=16'h0010, WrData=16'hBEEF, held to MemReady; then MemRead Addr=16'h0010.
  - MemReady arrives 4 edges after each strobe is sampled.
  - RdData=16'hBEEF; IR unchanged.
- Fetch: MemRead+IRWrite at Addr=16'h0010.
  - IR=16'hBEEF and RdData=16'hBEEF in the same cycle as MemReady.
- Out-of-range, DEPTH=200: MemWrite Addr=16'd200 data 16'h1234, then MemRead Addr=16'd200.
  - Both requests give Error and MemReady together; RdData=0.
  - Addr 8'd200 is never written; a later read of Addr=16'd199 is unaffected.
- Illegal and holdoff:
  - MemRead=MemWrite=1 -> one Error pulse, no MemReady, array unchanged.
  - Keep MemRead high after MemReady -> no second access until the strobe drops for 1 cycle.
- Reset mid-access: assert Reset during WAIT of a write to 16'h0020.
  - Outputs clear immediately (asynchronous).
  - After INIT, a read of 16'h0020 returns 0.

Source files
------------

// File: rtl/stack_mem_pkg.sv
// stack_mem_pkg: shared state encoding, op codes and width defaults for stack_mem_responder
package stack_mem_pkg;
    localparam int DW_DEF = 16;
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;
    typedef enum logic [2:0] {INIT, IDLE, CAPT, WAIT, ACC, DONE} state_t;
endpackage

// File: rtl/stack_mem_responder_if.sv
// stack_mem_responder_if: strobe/data bus between the datapath controller and the memory responder
interface stack_mem_responder_if #(parameter int DW = 16);
    logic          i_mem_read;
    logic          i_mem_write;
    logic          i_ir_write;
    logic [15:0]   i_addr;
    logic [DW-1:0] i_wr_data;
    logic [DW-1:0] o_rd_data;
    logic [DW-1:0] o_ir;
    logic          o_mem_ready;
    logic          o_busy;
    logic          o_error;
    modport master (
        output i_mem_read, i_mem_write, i_ir_write, i_addr, i_wr_data,
        input  o_rd_data, o_ir, o_mem_ready, o_busy, o_error
    );
    modport slave (
        input  i_mem_read, i_mem_write, i_ir_write, i_addr, i_wr_data,
        output o_rd_data, o_ir, o_mem_ready, o_busy, o_error
    );
endinterface

// File: rtl/mem_array_sp.sv
// mem_array_sp: single-port synchronous RAM, read data valid the cycle after the address
module mem_array_sp #(
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    parameter int DW    = 16
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/stack_mem_responder.sv
// stack_mem_responder: memory responder with wait states, range check and post-reset zero fill
module stack_mem_responder
    import stack_mem_pkg::*;
#(
    parameter int AW          = 8,
    parameter int DEPTH       = 256,
    parameter int DW          = DW_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    stack_mem_responder_if.slave bus
);
    localparam logic [AW:0] CNT_LAST  = (AW+1)'(DEPTH - 1);
    localparam logic [16:0] ADDR_LIM  = 17'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    state_t        r_state, w_next;
    logic [AW:0]   r_cnt;
    logic [3:0]    r_wcnt;
    logic [15:0]   r_addr;
    logic [DW-1:0] r_wdata, r_rd_data, r_ir, w_ram_rdata, w_ram_wdata;
    logic          r_op, r_irw, r_oor, r_ready, r_error;
    logic          w_oor, w_both, w_any, w_we;
    logic [AW-1:0] w_ram_addr;
    assign w_oor  = {1'b0, r_addr} >= ADDR_LIM;
    assign w_both = bus.i_mem_read && bus.i_mem_write;
    assign w_any  = bus.i_mem_read || bus.i_mem_write;
    // the latched address sits on the RAM during CAPT/WAIT so ACC sees its read data
    assign w_ram_addr  = r_state == INIT ? r_cnt[AW-1:0] : r_addr[AW-1:0];
    assign w_ram_wdata = r_state == INIT ? '0 : r_wdata;
    assign w_we        = r_state == INIT || (r_state == ACC && r_op == OP_WR && !r_oor);
    mem_array_sp #(.AW(AW), .DEPTH(DEPTH), .DW(DW)) u_mem (
        .i_clk  (i_clk),
        .i_we   (w_we),
        .i_addr (w_ram_addr),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_ram_rdata)
    );
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= INIT;
        else          r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            INIT:    w_next = r_cnt == CNT_LAST ? IDLE : INIT;
            IDLE:    w_next = w_both ? DONE : w_any ? CAPT : IDLE;
            CAPT:    w_next = (w_oor || WAIT_CYCLES == 0) ? ACC : WAIT;
            WAIT:    w_next = r_wcnt == 4'd1 ? ACC : WAIT;
            ACC:     w_next = DONE;
            DONE:    w_next = w_any ? DONE : IDLE;
            default: w_next = INIT;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_wcnt    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_op      <= OP_RD;
            r_irw     <= 1'b0;
            r_oor     <= 1'b0;
            r_rd_data <= '0;
            r_ir      <= '0;
            r_ready   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_ready <= r_state == ACC;
            r_error <= (r_state == ACC && r_oor) || (r_state == IDLE && w_both);
            if (r_state == INIT) r_cnt <= r_cnt + 1'b1;
            if (r_state == IDLE) begin
                r_addr  <= bus.i_addr;
                r_wdata <= bus.i_wr_data;
                r_op    <= bus.i_mem_write ? OP_WR : OP_RD;
                r_irw   <= bus.i_ir_write;
                r_wcnt  <= WAIT_INIT;
            end
            if (r_state == CAPT) r_oor <= w_oor;
            if (r_state == WAIT) r_wcnt <= r_wcnt - 1'b1;
            if (r_state == ACC && (r_op == OP_RD || r_oor)) r_rd_data <= r_oor ? '0 : w_ram_rdata;
            if (r_state == ACC && r_op == OP_RD && r_irw && !r_oor) r_ir <= w_ram_rdata;
        end
    assign bus.o_rd_data   = r_rd_data;
    assign bus.o_ir        = r_ir;
    assign bus.o_mem_ready = r_ready;
    assign bus.o_error     = r_error;
    assign bus.o_busy      = r_state inside {INIT, CAPT, WAIT, DONE};
endmodule

// File: tb/tb_stack_mem_responder.sv
// tb_stack_mem_responder: randomized and directed checks against a transaction-level model
module tb_stack_mem_responder;
    localparam int DEPTH = 200;
    localparam int W     = 1;
    localparam int INF   = 1 << 30;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int cyc = 0, ntot = 0, nbad = 0;
    int ready_cyc = -1, err_cyc = -1, acc_cyc = -1, pend_cyc = -1;
    int b_start = INF, b_end = INF, init_end = INF;
    logic [15:0] exp_rd = '0, exp_ir = '0, pend_rd = '0, pend_ir = '0;
    logic [15:0] at_rd, at_ir;
    logic at_err;
    logic [15:0] mdl [DEPTH];
    bit chk_en = 0;
    stack_mem_responder_if #(.DW(16)) bus ();
    stack_mem_responder #(.AW(8), .DEPTH(DEPTH), .DW(16), .WAIT_CYCLES(W)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] want);
        ntot++;
        if (act !== want) begin
            nbad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask
    // cycle-by-cycle comparison against the transaction timeline the driver records
    always @(negedge clk) if (chk_en) begin
        if (cyc == pend_cyc) begin
            exp_rd = pend_rd;
            exp_ir = pend_ir;
        end
        check("mem_ready", 16'(bus.o_mem_ready), 16'(cyc == ready_cyc));
        check("error", 16'(bus.o_error), 16'(cyc == err_cyc));
        check("busy", 16'(bus.o_busy), 16'(cyc < init_end || (cyc >= b_start && cyc < b_end && cyc != acc_cyc)));
        check("rd_data", bus.o_rd_data, exp_rd);
        check("ir", bus.o_ir, exp_ir);
    end
    task automatic to_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        ready_cyc = -1; err_cyc = -1; acc_cyc = -1; pend_cyc = -1;
        b_start = INF; b_end = INF; init_end = INF;
        exp_rd = '0; exp_ir = '0;
        foreach (mdl[i]) mdl[i] = '0;
    endtask
    task automatic release_reset();
        rst_n = 1'b1;
        init_end = cyc + DEPTH;
    endtask
    task automatic issue(input logic rd, input logic wr, input logic irw,
                         input logic [15:0] a, input logic [15:0] d, output int lat);
        int s;
        logic oor;
        s = cyc + 1;
        oor = int'(a) >= DEPTH;
        bus.i_mem_read = rd; bus.i_mem_write = wr; bus.i_ir_write = irw;
        bus.i_addr = a; bus.i_wr_data = d;
        b_start = s; b_end = INF; pend_cyc = -1;
        if (rd && wr) begin
            lat = 1;
            err_cyc = s; ready_cyc = -1; acc_cyc = -1;
        end else begin
            lat = oor ? 3 : W + 3;
            ready_cyc = s + lat - 1;
            acc_cyc = ready_cyc - 1;
            err_cyc = oor ? ready_cyc : -1;
            pend_cyc = ready_cyc; pend_rd = exp_rd; pend_ir = exp_ir;
            if (oor) pend_rd = '0;
            else if (wr) mdl[a[7:0]] = d;
            else begin
                pend_rd = mdl[a[7:0]];
                if (irw) pend_ir = mdl[a[7:0]];
            end
        end
    endtask
    task automatic finish(input int lat, input int hold);
        int n = 0;
        while (!(lat == 1 ? bus.o_error : bus.o_mem_ready) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 16'(n), 16'(lat));
        at_err = bus.o_error; at_rd = bus.o_rd_data; at_ir = bus.o_ir;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0; bus.i_ir_write = 1'b0;
        b_end = cyc + 1;
        to_cyc(b_end);
    endtask
    task automatic txn(input logic rd, input logic wr, input logic irw,
                       input logic [15:0] a, input logic [15:0] d, input int hold);
        int lat;
        issue(rd, wr, irw, a, d, lat);
        finish(lat, hold);
    endtask
    initial begin
        #500000;
        nbad++;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
    initial begin
        int lat, op, gap, hold;
        logic [15:0] a;
        bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0; bus.i_ir_write = 1'b0;
        bus.i_addr = '0; bus.i_wr_data = '0;
        #2 do_reset();
        #1 chk_en = 1;
        repeat (3) @(posedge clk);
        #1 release_reset();
        to_cyc(init_end - 1);
        check("busy_last_init", 16'(bus.o_busy), 16'd1);
        to_cyc(init_end);
        check("busy_after_init", 16'(bus.o_busy), 16'd0);
        txn(1, 0, 0, 16'h0033, 16'h0, 0);
        check("zero_after_init", at_rd, 16'h0000);
        txn(0, 1, 0, 16'h0010, 16'hBEEF, 1);
        txn(1, 0, 0, 16'h0010, 16'h0, 0);
        check("rd_beef", at_rd, 16'hBEEF);
        check("ir_kept", at_ir, 16'h0000);
        txn(1, 0, 1, 16'h0010, 16'h0, 0);
        check("fetch_ir", at_ir, 16'hBEEF);
        check("fetch_rd", at_rd, 16'hBEEF);
        txn(0, 1, 0, 16'd199, 16'h5A5A, 0);
        txn(1, 0, 0, 16'd199, 16'h0, 0);
        txn(0, 1, 0, 16'd200, 16'h1234, 0);
        check("oor_wr_err", 16'(at_err), 16'd1);
        check("oor_wr_rd", at_rd, 16'h0000);
        txn(1, 0, 0, 16'd199, 16'h0, 0);
        txn(1, 0, 0, 16'd200, 16'h0, 0);
        check("oor_rd_err", 16'(at_err), 16'd1);
        check("oor_rd_zero", at_rd, 16'h0000);
        txn(1, 0, 0, 16'd199, 16'h0, 0);
        check("rd_199", at_rd, 16'h5A5A);
        txn(1, 1, 0, 16'h0010, 16'hDEAD, 2);
        check("illegal_err", 16'(at_err), 16'd1);
        txn(1, 0, 0, 16'h0010, 16'h0, 3);
        check("array_kept", at_rd, 16'hBEEF);
        issue(0, 1, 0, 16'h0020, 16'hCAFE, lat);
        to_cyc(cyc + 2);
        do_reset();
        #1;
        check("rst_ready", 16'(bus.o_mem_ready), 16'd0);
        check("rst_busy", 16'(bus.o_busy), 16'd1);
        check("rst_rd", bus.o_rd_data, 16'h0000);
        check("rst_ir", bus.o_ir, 16'h0000);
        bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0;
        to_cyc(cyc + 2);
        release_reset();
        to_cyc(init_end);
        txn(1, 0, 0, 16'h0020, 16'h0, 0);
        check("rd_after_abort", at_rd, 16'h0000);
        repeat (150) begin
            op = int'($urandom_range(0, 9));
            case ($urandom_range(0, 3))
                0:       a = 16'($urandom_range(0, 7));
                1:       a = 16'($urandom_range(190, 209));
                2:       a = 16'($urandom);
                default: a = 16'($urandom_range(0, 199));
            endcase
            hold = int'($urandom_range(0, 2));
            gap  = int'($urandom_range(0, 2));
            txn(op == 0 || op >= 5, op <= 4, op >= 8, a, 16'($urandom), hold);
            to_cyc(cyc + gap);
        end
        to_cyc(cyc + 2);
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end
endmodule
